// File: rtl/ami_wsplit.sv
// rtl/ami_wsplit.sv - AXI write engine splitting one command into boundary-safe INCR bursts
module ami_wsplit #(
  parameter int AXI_DW   = 128,
  parameter int AXI_AW   = 32,
  parameter int AXI_IW   = 8,
  parameter int AXI_LW   = 8,
  parameter int CMD_LW   = 16,
  parameter int MAX_BLEN = 16,
  parameter int AMI_OD   = 4,
  parameter int BOUNDARY = 4096
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [AXI_IW-1:0]   cmd_id,
  input  logic [AXI_AW-1:0]   cmd_addr,
  input  logic [CMD_LW-1:0]   cmd_beats,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [AXI_DW-1:0]   usr_wdata,
  input  logic [AXI_DW/8-1:0] usr_wstrb,
  input  logic                usr_wvalid,
  output logic                usr_wready,
  output logic [1:0]          done_resp,
  output logic                done_valid,
  input  logic                done_ready,
  output logic                busy,
  output logic [AXI_IW-1:0]   AWID,
  output logic [AXI_AW-1:0]   AWADDR,
  output logic [AXI_LW-1:0]   AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [AXI_DW-1:0]   WDATA,
  output logic [AXI_DW/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [AXI_IW-1:0]   BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY
);
  localparam int BYTES = AXI_DW / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam int XW    = ((CMD_LW > AXI_AW) ? CMD_LW : AXI_AW) + AXI_LW + 2;
  localparam int OW    = $clog2(AMI_OD + 1);
  localparam int PW    = (AMI_OD > 1) ? $clog2(AMI_OD) : 1;
  localparam int BLW   = AXI_LW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic              run_q;
  logic [AXI_AW-1:0] addr_q;
  logic [CMD_LW-1:0] rem_q;
  logic [BLW-1:0]    len_q;
  logic              len_vld_q;
  logic [1:0]        worst_q;
  logic [OW-1:0]     ost_q;
  logic [BLW-1:0]    len_mem [AMI_OD];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [OW-1:0]     fcnt;
  logic [AXI_LW-1:0] beat_q;

  logic cmd_hs, aw_hs, w_hs, b_hs, aw_load, fifo_ne, fifo_full;
  logic [1:0]     bresp_sev;
  logic [BLW-1:0] head_len;
  logic [XW-1:0]  rem_x, bnd_x, max_x, len_x;
  logic           unused_bid;

  assign unused_bid = ^BID;
  assign AWSIZE     = 3'(SZ);
  assign AWBURST    = 2'b01;

  assign fifo_ne    = (fcnt != '0);
  assign fifo_full  = (fcnt == OW'(AMI_OD));
  assign head_len   = len_mem[rd_ptr];
  assign WVALID     = usr_wvalid & fifo_ne;
  assign usr_wready = WREADY & fifo_ne;
  assign WDATA      = usr_wdata;
  assign WSTRB      = usr_wstrb;
  assign WLAST      = fifo_ne & ({1'b0, beat_q} == head_len - BLW'(1));

  assign cmd_hs    = cmd_valid & cmd_ready;
  assign aw_hs     = AWVALID & AWREADY;
  assign w_hs      = WVALID & WREADY;
  assign b_hs      = BVALID & BREADY;
  assign bresp_sev = (BRESP == 2'b01) ? 2'b00 : BRESP;

  // Next burst length, evaluated wide so the boundary room never wraps
  always_comb begin
    rem_x = XW'(rem_q);
    max_x = XW'(MAX_BLEN);
    bnd_x = (XW'(BOUNDARY) - (XW'(addr_q) & XW'(BOUNDARY - 1))) >> SZ;
    len_x = rem_x;
    if (max_x < len_x) len_x = max_x;
    if (bnd_x < len_x) len_x = bnd_x;
  end

  assign aw_load = (state_q == ISSUE) & ~AWVALID & len_vld_q & (rem_q != '0) &
                   (ost_q < OW'(AMI_OD)) & ~fifo_full;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (cmd_hs) state_d = (cmd_beats == '0) ? DONE : ISSUE;
      ISSUE: if (aw_hs && rem_q == CMD_LW'(len_q)) state_d = DRAIN;
      DRAIN: if (rem_q == '0 && ost_q == '0 && !fifo_ne && !b_hs && !w_hs) state_d = DONE;
      DONE:  if (done_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (state_q == IDLE) & run_q;
    busy       = (state_q != IDLE);
    BREADY     = (state_q == ISSUE) | (state_q == DRAIN);
    done_valid = (state_q == DONE);
    done_resp  = (state_q == DONE) ? worst_q : 2'b00;
  end

  // The length is re-registered after every address change, giving AW a clean pipeline stage
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      run_q     <= 1'b0;
      AWID      <= '0;
      AWADDR    <= '0;
      AWLEN     <= '0;
      AWVALID   <= 1'b0;
      addr_q    <= '0;
      rem_q     <= '0;
      len_q     <= '0;
      len_vld_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      len_q <= BLW'(len_x);
      if (cmd_hs) begin
        AWID      <= cmd_id;
        addr_q    <= cmd_addr & ~AXI_AW'(BYTES - 1);
        rem_q     <= cmd_beats;
        len_vld_q <= 1'b0;
      end else if (aw_hs) begin
        addr_q    <= addr_q + (AXI_AW'(len_q) << SZ);
        rem_q     <= rem_q - CMD_LW'(len_q);
        AWVALID   <= 1'b0;
        len_vld_q <= 1'b0;
      end else if (aw_load) begin
        AWVALID <= 1'b1;
        AWADDR  <= addr_q;
        AWLEN   <= AXI_LW'(len_q - BLW'(1));
      end else begin
        len_vld_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ost_q   <= '0;
      worst_q <= 2'b00;
    end else begin
      case ({aw_hs, b_hs})
        2'b10:   ost_q <= ost_q + OW'(1);
        2'b01:   ost_q <= ost_q - OW'(1);
        default: ost_q <= ost_q;
      endcase
      if (cmd_hs) worst_q <= 2'b00;
      else if (b_hs && bresp_sev > worst_q) worst_q <= bresp_sev;
    end
  end

  // Length FIFO: one entry per accepted AW, popped by the WLAST beat
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < AMI_OD; i++) len_mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
      beat_q <= '0;
    end else begin
      if (aw_hs) begin
        len_mem[wr_ptr] <= len_q;
        wr_ptr <= (wr_ptr == PW'(AMI_OD - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (w_hs && WLAST) rd_ptr <= (rd_ptr == PW'(AMI_OD - 1)) ? '0 : rd_ptr + PW'(1);
      case ({aw_hs, w_hs && WLAST})
        2'b10:   fcnt <= fcnt + OW'(1);
        2'b01:   fcnt <= fcnt - OW'(1);
        default: fcnt <= fcnt;
      endcase
      if (w_hs) beat_q <= WLAST ? '0 : beat_q + AXI_LW'(1);
    end
  end
endmodule

// File: tb/tb_ami_wsplit.sv
// tb/tb_ami_wsplit.sv - directed self-checking bench for ami_wsplit with a burst-plan model
module tb_ami_wsplit;
  logic         ACLK = 1'b0;
  logic         ARESETn;
  logic [7:0]   cmd_id;
  logic [31:0]  cmd_addr;
  logic [15:0]  cmd_beats;
  logic         cmd_valid, cmd_ready;
  logic [127:0] usr_wdata;
  logic [15:0]  usr_wstrb;
  logic         usr_wvalid, usr_wready;
  logic [1:0]   done_resp;
  logic         done_valid, done_ready, busy;
  logic [7:0]   AWID;
  logic [31:0]  AWADDR;
  logic [7:0]   AWLEN;
  logic [2:0]   AWSIZE;
  logic [1:0]   AWBURST;
  logic         AWVALID, AWREADY;
  logic [127:0] WDATA;
  logic [15:0]  WSTRB;
  logic         WLAST, WVALID, WREADY;
  logic [7:0]   BID;
  logic [1:0]   BRESP;
  logic         BVALID, BREADY;

  always #5 ACLK = ~ACLK;

  ami_wsplit dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb),
    .usr_wvalid(usr_wvalid), .usr_wready(usr_wready),
    .done_resp(done_resp), .done_valid(done_valid), .done_ready(done_ready),
    .busy(busy),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  int checks = 0;
  int passes = 0;

  task automatic ceq(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Burst plan from the rules: cap by remaining beats, 16-beat limit and 4 KiB room
  function automatic int model_len(input longint a, input int rem);
    int bl, room;
    bl = rem;
    if (bl > 16) bl = 16;
    room = int'((64'd4096 - (a % 64'd4096)) / 64'd16);
    if (room < bl) bl = room;
    return bl;
  endfunction

  function automatic logic [127:0] data_of(input int n);
    return {32'(n), ~32'(n), 32'(n) ^ 32'h5A5A5A5A, 32'hC0DE0000 ^ 32'(n)};
  endfunction

  function automatic logic [15:0] strb_of(input int n);
    return 16'(n * 4951 + 3);
  endfunction

  function automatic logic [1:0] sev(input logic [1:0] r);
    return (r == 2'b01) ? 2'b00 : r;
  endfunction

  longint     exp_aw_addr[$];
  int         exp_aw_len[$];
  bit         exp_last[$];
  logic [1:0] resp_q[$];
  logic [7:0] exp_id;
  logic [1:0] exp_worst, last_done;
  int  aw_cnt = 0, w_cnt = 0, wl_cnt = 0, b_given = 0, done_cnt = 0;
  int  base_aw, base_w, base_wl, base_done;
  bit  b_en, stall, b_hs, aw_prev_stall;
  int  b_budget;
  logic [31:0] sv_addr;
  logic [7:0]  sv_len;

  task automatic build_model(input logic [31:0] addr, input int beats);
    longint a;
    int rem, bl;
    a = longint'(addr & ~32'hF);
    rem = beats;
    while (rem > 0) begin
      bl = model_len(a, rem);
      exp_aw_addr.push_back(a);
      exp_aw_len.push_back(bl - 1);
      for (int k = 0; k < bl; k++) exp_last.push_back(k == bl - 1);
      a += longint'(bl * 16);
      rem -= bl;
    end
  endtask

  // Monitor at negedge, drive at posedge+1
  initial begin
    longint ea;
    int el;
    bit lb;
    AWREADY = 1'b1; WREADY = 1'b1; usr_wvalid = 1'b0; usr_wdata = '0; usr_wstrb = '0;
    BVALID = 1'b0; BRESP = 2'b00; BID = 8'h00;
    aw_prev_stall = 1'b0; b_hs = 1'b0; exp_worst = 2'b00; exp_id = 8'h00;
    sv_addr = '0; sv_len = '0; last_done = 2'b00;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        exp_aw_addr.delete(); exp_aw_len.delete(); exp_last.delete();
        aw_prev_stall = 1'b0; b_hs = 1'b0; b_given = wl_cnt;
      end else begin
        if (cmd_valid && cmd_ready) begin
          build_model(cmd_addr, int'(cmd_beats));
          exp_worst = 2'b00;
          exp_id = cmd_id;
        end
        if (aw_prev_stall) begin
          ceq("aw_hold_valid", AWVALID, 1'b1);
          ceq("aw_hold_addr", AWADDR, sv_addr);
          ceq("aw_hold_len", AWLEN, sv_len);
        end
        aw_prev_stall = AWVALID && !AWREADY;
        sv_addr = AWADDR;
        sv_len = AWLEN;
        if (AWVALID && AWREADY) begin
          aw_cnt++;
          if (exp_aw_addr.size() == 0) ceq("aw_extra", AWVALID, 1'b0);
          else begin
            ea = exp_aw_addr.pop_front();
            el = exp_aw_len.pop_front();
            ceq("awaddr", AWADDR, 32'(ea));
            ceq("awlen", AWLEN, 8'(el));
            ceq("awid", AWID, exp_id);
            ceq("awsize_burst", {AWSIZE, AWBURST}, 5'b100_01);
          end
        end
        if (WVALID && WREADY) begin
          ceq("wdata", WDATA, data_of(w_cnt));
          ceq("wstrb", WSTRB, strb_of(w_cnt));
          if (exp_last.size() == 0) ceq("w_extra", WVALID, 1'b0);
          else begin
            lb = exp_last.pop_front();
            ceq("wlast", WLAST, lb);
          end
          w_cnt++;
          if (WLAST) wl_cnt++;
        end
        b_hs = BVALID && BREADY;
        if (done_valid && done_ready) begin
          ceq("done_resp_model", done_resp, exp_worst);
          last_done = done_resp;
          done_cnt++;
        end
      end
      @(posedge ACLK);
      #1;
      usr_wdata = data_of(w_cnt);
      usr_wstrb = strb_of(w_cnt);
      AWREADY    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      WREADY     = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      usr_wvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!ARESETn) BVALID = 1'b0;
      else begin
        if (b_hs) BVALID = 1'b0;
        if (!BVALID && b_given < wl_cnt && (b_en || b_budget > 0)) begin
          BVALID = 1'b1;
          BRESP = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
          if (sev(BRESP) > exp_worst) exp_worst = sev(BRESP);
          b_given++;
          if (!b_en) b_budget--;
        end
      end
    end
  end

  task automatic chk_reset(input string tag);
    ceq({tag, "_cmd_ready"}, cmd_ready, 1'b0);
    ceq({tag, "_awvalid"}, AWVALID, 1'b0);
    ceq({tag, "_wvalid"}, WVALID, 1'b0);
    ceq({tag, "_usr_wready"}, usr_wready, 1'b0);
    ceq({tag, "_bready"}, BREADY, 1'b0);
    ceq({tag, "_done_valid"}, done_valid, 1'b0);
    ceq({tag, "_done_resp"}, done_resp, 2'b00);
    ceq({tag, "_busy"}, busy, 1'b0);
    ceq({tag, "_aw_fields"}, {AWID, AWADDR, AWLEN}, 48'h0);
  endtask

  task automatic start_test();
    base_aw = aw_cnt; base_w = w_cnt; base_wl = wl_cnt; base_done = done_cnt;
  endtask

  task automatic send_cmd(input logic [7:0] id, input logic [31:0] addr, input logic [15:0] beats);
    bit ok;
    cmd_id = id; cmd_addr = addr; cmd_beats = beats; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge ACLK);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    @(posedge ACLK);
    #1;
    cmd_valid = 1'b0;
    ceq("cmd_accept", ok, 1'b1);
  endtask

  task automatic finish_test(input string tag, input logic [1:0] resp, input int n_aw, input int n_w, input int n_wl);
    bit ok;
    done_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge ACLK);
      #3;
      if (done_cnt > base_done) begin ok = 1'b1; break; end
    end
    ceq({tag, "_done_seen"}, ok, 1'b1);
    ceq({tag, "_done_resp"}, last_done, resp);
    ceq({tag, "_aw_count"}, aw_cnt - base_aw, n_aw);
    ceq({tag, "_w_count"}, w_cnt - base_w, n_w);
    ceq({tag, "_wlast_count"}, wl_cnt - base_wl, n_wl);
    ceq({tag, "_model_drained"}, exp_aw_addr.size() + exp_last.size(), 0);
  endtask

  initial begin
    bit ok;
    ARESETn = 1'b0; cmd_valid = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_beats = '0;
    done_ready = 1'b1; b_en = 1'b1; b_budget = 0; stall = 1'b0;
    repeat (3) @(posedge ACLK);
    #3;
    chk_reset("rst");
    ARESETn = 1'b1;
    @(posedge ACLK);
    #3;

    // Boundary split at 0xFC0, 40 beats
    ceq("pin_len0", model_len(64'hFC0, 40), 4);
    ceq("pin_len1", model_len(64'h1000, 36), 16);
    ceq("pin_len2", model_len(64'h1100, 20), 16);
    ceq("pin_len3", model_len(64'h1200, 4), 4);
    start_test();
    send_cmd(8'h11, 32'h0000_0FC0, 16'd40);
    finish_test("split", 2'd0, 4, 40, 4);

    // Outstanding limit with B withheld
    b_en = 1'b0; b_budget = 0;
    start_test();
    send_cmd(8'h22, 32'h0000_2000, 16'd100);
    repeat (150) @(posedge ACLK);
    #3;
    ceq("od_aw_count", aw_cnt - base_aw, 4);
    ceq("od_awvalid_low", AWVALID, 1'b0);
    b_budget = 1;
    repeat (40) @(posedge ACLK);
    #3;
    ceq("od_aw_after_one_b", aw_cnt - base_aw, 5);
    ceq("od_awvalid_low2", AWVALID, 1'b0);
    b_en = 1'b1;
    finish_test("od", 2'd0, 7, 100, 7);

    // Response merging
    resp_q.push_back(2'b00); resp_q.push_back(2'b10); resp_q.push_back(2'b01); resp_q.push_back(2'b00);
    start_test();
    send_cmd(8'h33, 32'h0000_0000, 16'd64);
    finish_test("slverr", 2'd2, 4, 64, 4);
    resp_q.push_back(2'b00); resp_q.push_back(2'b11); resp_q.push_back(2'b10); resp_q.push_back(2'b01);
    start_test();
    send_cmd(8'h34, 32'h0000_0000, 16'd64);
    finish_test("decerr", 2'd3, 4, 64, 4);

    // Zero-beat command, completion held off
    done_ready = 1'b0;
    start_test();
    send_cmd(8'h44, 32'h0000_0123, 16'd0);
    @(negedge ACLK);
    ceq("zero_done_rise", done_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      ceq("zero_hold_valid", done_valid, 1'b1);
      ceq("zero_hold_resp", done_resp, 2'b00);
      ceq("zero_hold_cmd_ready", cmd_ready, 1'b0);
    end
    finish_test("zero", 2'd0, 0, 0, 0);

    // Random stalls, 33 beats from 0
    ceq("pin_s0", model_len(64'h0, 33), 16);
    ceq("pin_s1", model_len(64'h100, 17), 16);
    ceq("pin_s2", model_len(64'h200, 1), 1);
    stall = 1'b1;
    start_test();
    send_cmd(8'h55, 32'h0000_0000, 16'd33);
    finish_test("stall", 2'd0, 3, 33, 3);
    stall = 1'b0;

    // Reset mid-burst after 7 beats
    start_test();
    send_cmd(8'h66, 32'h0000_0100, 16'd32);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge ACLK);
      #3;
      if (w_cnt - base_w >= 7) begin ok = 1'b1; break; end
    end
    ceq("abort_reach_7", ok, 1'b1);
    ARESETn = 1'b0;
    #1;
    chk_reset("abort");
    repeat (2) @(posedge ACLK);
    #3;
    ARESETn = 1'b1;
    repeat (10) @(posedge ACLK);
    #3;
    ceq("abort_no_done", done_cnt - base_done, 0);
    start_test();
    send_cmd(8'h77, 32'h0000_0040, 16'd4);
    finish_test("post_rst", 2'd0, 1, 4, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ami_wsplit.md
Name: ami_wsplit

Overview:
Single-clock AXI master write engine that takes one user write command (start address, beat count) and issues it as a sequence of INCR bursts. Each burst is at most MAX_BLEN beats and never crosses a BOUNDARY-byte address boundary. The engine generates WLAST by counting beats, enforces an outstanding-burst limit, and merges all B responses into one completion per command. It sits between the DMA command logic and the AXI interconnect, in the ACLK domain; any usr_clk crossing is done upstream.

Parameters:
AXI_DW, 128, AXI data width (bits); BYTES = AXI_DW/8, a power of 2.
AXI_AW, 32, address width.
AXI_IW, 8, ID width.
AXI_LW, 8, AWLEN width.
CMD_LW, 16, width of the command beat count.
MAX_BLEN, 16, maximum beats per burst; must be between 1 and 2^AXI_LW.
AMI_OD, 4, maximum AW-accepted bursts without a B response.
BOUNDARY, 4096, burst-crossing boundary in bytes; a power of 2 and at least BYTES*MAX_BLEN is not required.

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
cmd_id  in  AXI_IW  ID used for all bursts of the command
cmd_addr  in  AXI_AW  start byte address; low log2(BYTES) bits are forced to 0
cmd_beats  in  CMD_LW  total beats
cmd_valid / cmd_ready  in / out  1  command handshake
usr_wdata  in  AXI_DW  write data
usr_wstrb  in  BYTES  write strobes
usr_wvalid / usr_wready  in / out  1  data handshake
done_resp  out  2  merged response
done_valid / done_ready  out / in  1  completion handshake
busy  out  1  high whenever the FSM is not in IDLE
AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID / AWREADY  out / in  AXI AW channel
WDATA, WSTRB, WLAST, WVALID / WREADY  out / in  AXI W channel
BID, BRESP, BVALID / BREADY  in / out  AXI B channel

Behaviour:
- Reset: ARESETn is asynchronous, active-low; the block is clocked on ACLK. In reset, FSM=IDLE and all counters and the length FIFO are cleared. Outputs in reset: cmd_ready=0, AWVALID=0, WVALID=0, BREADY=0, done_valid=0, busy=0, done_resp=0, AW outputs=0.
- Fixed fields: AWSIZE=log2(BYTES), AWBURST=2'b01, AWID=latched cmd_id.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: cmd_ready=1. On cmd handshake, latch id, addr and rem=cmd_beats, clear worst_resp, then go to ISSUE. If cmd_beats=0, go to DONE instead with done_resp=OKAY.
- Burst length: len = min(rem, MAX_BLEN, (BOUNDARY - addr mod BOUNDARY)/BYTES). Compute it with widths extended so no intermediate value truncates.
- AW registers: AWADDR, AWLEN=len-1 and AWVALID are registered. AWVALID is asserted when rem>0, ost_cc<AMI_OD and the length FIFO is not full. Once AWVALID is asserted, AW fields stay stable until AWREADY.
- On AW handshake: addr+=len*BYTES, rem-=len, ost_cc+=1, push len into the length FIFO (depth AMI_OD). When rem reaches 0, go to DRAIN.
- W path: W may start only for a burst whose AW has already been accepted.
  - WVALID = usr_wvalid & length FIFO non-empty.
  - usr_wready = WREADY & length FIFO non-empty.
  - WDATA/WSTRB pass through combinationally.
- WLAST = (beat_cc == head_len-1). On a W handshake with WLAST, pop the length FIFO and clear beat_cc; otherwise beat_cc increments on each handshake.
- B channel: BREADY=1 in ISSUE and DRAIN. On a B handshake, ost_cc-=1 and worst_resp=max(worst_resp, sev(BRESP)). sev maps EXOKAY to OKAY; DECERR(3) > SLVERR(2) > OKAY(0). BID is not checked.
- Simultaneous AW and B handshakes in the same cycle leave ost_cc unchanged.
- DRAIN -> DONE when rem=0, ost_cc=0, the length FIFO is empty, and no handshake is in progress.
- DONE: done_valid=1 with done_resp=worst_resp, held stable until done_ready, then return to IDLE.
- Total latency from cmd handshake to first AWVALID is 2 cycles.
- Reset mid-operation abandons the command; no completion is produced.

Test Plan:
- DW=128, cmd_addr=0xFC0, beats=40, all ready=1 -> AW pairs (addr,AWLEN) = (0xFC0,3), (0x1000,15), (0x1100,15), (0x1200,3). Exactly 40 W beats with WLAST on beats 4, 20, 36, 40; done_resp=0.
- AMI_OD=4, beats=100, BVALID held low -> exactly 4 AW handshakes, then AWVALID=0. Releasing one B produces exactly one more AW.
- B responses OKAY, SLVERR, EXOKAY, OKAY for a 4-burst command -> done_resp=2. Repeat with one DECERR -> done_resp=3.
- cmd_beats=0 -> no AW or W traffic; done_valid rises 1 cycle later with done_resp=0. With done_ready=0 for 5 cycles, done_valid and done_resp stay stable and cmd_ready stays 0.
- Random WREADY/usr_wvalid/AWREADY stalls, beats=33 at addr 0x0 -> data order preserved, AW fields stable while stalled, WLAST on beats 16, 32, 33.
- ARESETn asserted mid-burst after 7 beats -> all outputs return to reset values asynchronously. A new 4-beat command after reset completes normally.
